mux_key_pipe: RTL

MUX_KEY_PIPE -- requirements
Module: mux_key_pipe

---
 rtl/mux_key_pkg.sv | 9 +
 rtl/mux_key_pipe_if.sv | 27 ++
 rtl/mux_key_match.sv | 25 ++
 rtl/mux_key_pipe.sv | 66 ++++++
 4 files changed

// File: rtl/mux_key_pkg.sv
// mux_key_pkg: default sizes and index-width helper for the keyed lookup pipe
package mux_key_pkg;
  localparam int NR_KEY_DEF = 4;
  localparam int KEY_LEN_DEF = 2;
  localparam int DATA_LEN_DEF = 8;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_key_pipe_if.sv
// mux_key_pipe_if: table write port plus lookup request/response channels
interface mux_key_pipe_if import mux_key_pkg::*; #(
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int IDX_W = idx_w(NR_KEY_DEF)
);
  logic wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [KEY_LEN-1:0] wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic clear;
  logic req_valid;
  logic req_ready;
  logic [KEY_LEN-1:0] req_key;
  logic resp_valid;
  logic resp_ready;
  logic [DATA_LEN-1:0] resp_data;
  logic resp_hit;
  modport master (
    output wr_en, wr_idx, wr_key, wr_data, clear, req_valid, req_key, resp_ready,
    input req_ready, resp_valid, resp_data, resp_hit
  );
  modport slave (
    input wr_en, wr_idx, wr_key, wr_data, clear, req_valid, req_key, resp_ready,
    output req_ready, resp_valid, resp_data, resp_hit
  );
endinterface

// File: rtl/mux_key_match.sv
// mux_key_match: combinational lowest-index-wins key matcher with miss default
module mux_key_match import mux_key_pkg::*; #(
  parameter int NR_KEY = NR_KEY_DEF,
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input logic [NR_KEY-1:0] valid,
  input logic [NR_KEY-1:0][KEY_LEN-1:0] keys,
  input logic [NR_KEY-1:0][DATA_LEN-1:0] data,
  input logic [KEY_LEN-1:0] key,
  input logic [DATA_LEN-1:0] dflt,
  output logic [DATA_LEN-1:0] rdata,
  output logic hit
);
  // scan from the top so the lowest matching index is assigned last
  always_comb begin
    rdata = dflt;
    hit = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--)
      if (valid[i] && keys[i] == key) begin
        rdata = data[i];
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/mux_key_pipe.sv
// mux_key_pipe: programmable key->data LUT with a 1-cycle registered lookup pipe
// MUX_KEY_PIPE_FWD_EN makes lookups see same-cycle clear/write; default sees the old table
module mux_key_pipe import mux_key_pkg::*; #(
  parameter int NR_KEY = NR_KEY_DEF,
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter logic [DATA_LEN-1:0] DEFAULT = '0
) (
  input logic clk,
  input logic rst_n,
  mux_key_pipe_if.slave bus
);
  logic [NR_KEY-1:0] valid, valid_n, we, lk_valid;
  logic [NR_KEY-1:0][KEY_LEN-1:0] keys, keys_n, lk_keys;
  logic [NR_KEY-1:0][DATA_LEN-1:0] data, data_n, lk_data;
  logic [DATA_LEN-1:0] m_data, resp_data;
  logic m_hit, resp_valid, resp_hit, accept;
  assign bus.req_ready = !resp_valid || bus.resp_ready;
  assign accept = bus.req_valid && bus.req_ready;
  // an out-of-range wr_idx matches no entry, so the write is dropped
  genvar i;
  for (i = 0; i < NR_KEY; i++) begin : g_ent
    assign we[i] = bus.wr_en && int'(bus.wr_idx) == i;
    assign valid_n[i] = we[i] || (valid[i] && !bus.clear);
    assign keys_n[i] = we[i] ? bus.wr_key : keys[i];
    assign data_n[i] = we[i] ? bus.wr_data : data[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= '0;
    else valid <= valid_n;
  always_ff @(posedge clk) begin
    keys <= keys_n;
    data <= data_n;
  end
`ifdef MUX_KEY_PIPE_FWD_EN
  assign lk_valid = valid_n;
  assign lk_keys = keys_n;
  assign lk_data = data_n;
`else
  assign lk_valid = valid;
  assign lk_keys = keys;
  assign lk_data = data;
`endif
  mux_key_match #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) u_match (
    .valid(lk_valid),
    .keys(lk_keys),
    .data(lk_data),
    .key(bus.req_key),
    .dflt(DEFAULT),
    .rdata(m_data),
    .hit(m_hit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_hit <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data <= m_data;
      resp_hit <= m_hit;
    end else if (bus.resp_ready) resp_valid <= 1'b0;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data = resp_data;
  assign bus.resp_hit = resp_hit;
endmodule
